ika2151_reg_sched: RTL and testbench
====================================

# ika2151_reg_sched

Register-write scheduler between the CPU bus interface and the time-multiplexed operator register files. It accepts address and data writes and issues global-register writes on the next phi1 cycle. Per-channel and per-operator writes are held until the 32-slot pipeline reaches the target slot. The block drives the BUSY flag seen by the CPU for a fixed number of phi1 cycles after every accepted data write.

## Interface
- BUSY_CYCLES, 64: phi1 cycles BUSY stays high after an accepted data write; legal range 33..255.
- i_EMUCLK  in  1  emulator master clock; all state on its rising edge
- i_RST  in  1  synchronous active-high reset, sampled on every i_EMUCLK edge regardless of enables
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active low; a low sample is an "enabled edge"
- i_CYCLE_01  in  1  slot-sync strobe from the timing generator, high for one phi1 cycle per 32
- i_ADDR_WR  in  1  CPU address-write strobe; any width of at least 1 EMUCLK
- i_DATA_WR  in  1  CPU data-write strobe; any width of at least 1 EMUCLK
- i_DIN  in  8  CPU data bus, sampled together with the strobe
- o_BUSY  out  1  CPU busy flag
- o_REG_WE  out  1  global register write, 0x00-0x1F, one phi1 cycle
- o_OP_WE  out  1  slot register write, 0x20-0xFF, one phi1 cycle
- o_REG_ADDR  out  8  write address, valid while either WE is high
- o_REG_DATA  out  8  write data, valid while either WE is high
- o_OP_SLOT  out  5  target slot, valid while o_OP_WE is high
- o_WR_DROP  out  1  data write rejected because BUSY was high, one phi1 cycle

## Operation
- Strobe capture, every EMUCLK edge:
  - A high i_ADDR_WR sets addr_pend and stores i_DIN in addr_buf.
  - A high i_DATA_WR sets data_pend and stores i_DIN in data_buf.
  - Both pend flags are cleared at the next enabled edge.
- Address latch: at an enabled edge with addr_pend set, cur_addr <= addr_buf. This is accepted in any state, including while BUSY.
- Data write: at an enabled edge with data_pend set:
  - If o_BUSY is 0, the write is accepted: wr_addr <= the address in effect, wr_data <= data_buf, busy_cnt <= BUSY_CYCLES-1, o_BUSY <= 1.
  - If o_BUSY is 1, the write is dropped and o_WR_DROP pulses.
  - If addr_pend and data_pend are set at the same edge, the address is applied first and the data write uses the new address.
- Slot counter, 5-bit, at each enabled edge: slot <= i_CYCLE_01 ? 1 : slot+1, wrapping 31 -> 0.
- Target slot:
  - addr 0x20-0x3F (channel registers): {2'b00, addr[2:0]}
  - addr 0x40-0xFF (operator registers): addr[4:0]
- FSM, advancing on enabled edges only:
  - IDLE: on an accepted write with addr < 0x20, assert o_REG_WE for the next phi1 cycle and go to HOLD. On an accepted write with addr >= 0x20, go to WAIT.
  - WAIT: when the pre-edge slot equals the target, assert o_OP_WE and o_OP_SLOT for the next phi1 cycle and go to HOLD. The write is always issued within 32 phi1 cycles.
  - HOLD: decrement busy_cnt each enabled edge. At 0, o_BUSY <= 0 and go to IDLE.
  - busy_cnt also decrements in WAIT. If it reaches 0 in WAIT the design is illegal; BUSY_CYCLES >= 33 prevents this.
- Reset: slot=0 and state IDLE. All outputs are 0: o_BUSY, both WEs, o_REG_ADDR, o_REG_DATA, o_OP_SLOT, o_WR_DROP. cur_addr=0, busy_cnt=0, both pend flags cleared.
- Reset mid-write aborts the pending write; no WE is issued afterwards.

## Timing
- All outputs are registered and change only on enabled edges or on reset.
- o_BUSY rises at the enabled edge that accepts the data write and stays high for exactly BUSY_CYCLES phi1 cycles.
- Global write latency: o_REG_WE is high during the phi1 cycle following the accepting edge, so latency is 1 phi1.
- Slot write latency: 1 to 32 phi1 cycles after acceptance, depending on slot alignment. The WE is high for exactly one phi1 cycle.
- Strobes arriving between enabled edges are never lost. Two address writes between one pair of enabled edges keep the last one.
- i_CYCLE_01 re-synchronizes slot on every occurrence; a misaligned counter is corrected within one pipeline frame.

## Test plan
- Reset, then i_CYCLE_01 every 32 phi1 -> slot is 1 in the cycle after the strobe; all outputs are 0 during and after reset.
- Address write 0x08, then data write 0x5A -> o_REG_WE high for 1 phi1 with ADDR=0x08, DATA=0x5A; o_BUSY high for exactly 64 phi1.
- Address write 0x6D, then data write 0x1F accepted when slot=20 -> o_OP_WE high in the phi1 cycle after the slot-13 edge (next frame), o_OP_SLOT=13; BUSY clears at 64.
- Address write 0x2B, then data write 0x33 -> o_OP_WE with o_OP_SLOT=3.
- Second data write 0x77 during BUSY -> o_WR_DROP pulses once; no WE issued; BUSY timing unchanged. Address write 0x10 during BUSY -> the pending write still uses the old address.
- Simultaneous address 0x0F and data 0x99 strobes in one phi1 cycle -> o_REG_WE with ADDR=0x0F. i_RST asserted during WAIT -> no o_OP_WE follows; o_BUSY=0.

Source files
------------

// File: rtl/ika2151_reg_sched.sv
// Register-write scheduler: captures CPU address/data strobes, issues global writes
// on the next phi1 cycle and slot writes when the 32-slot pipeline reaches the target.
module ika2151_reg_sched #(
  parameter int BUSY_CYCLES = 64
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_01,
  input  logic       i_ADDR_WR,
  input  logic       i_DATA_WR,
  input  logic [7:0] i_DIN,
  output logic       o_BUSY,
  output logic       o_REG_WE,
  output logic       o_OP_WE,
  output logic [7:0] o_REG_ADDR,
  output logic [7:0] o_REG_DATA,
  output logic [4:0] o_OP_SLOT,
  output logic       o_WR_DROP
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_addr_pend;
  logic       r_data_pend;
  logic [7:0] r_addr_buf;
  logic [7:0] r_data_buf;
  logic [7:0] r_cur_addr;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_busy_cnt;
  logic [4:0] r_slot;
  logic [4:0] r_op_slot;
  logic       r_busy;
  logic       r_reg_we;
  logic       r_op_we;
  logic       r_wr_drop;

  logic       w_en;
  logic [7:0] w_eff_addr;
  logic       w_accept;
  logic       w_is_global;
  logic [4:0] w_target;
  logic       w_slot_hit;
  logic       w_busy_zero;

  logic       w_busy_nxt;
  logic [7:0] w_busy_cnt_nxt;
  logic       w_reg_we_nxt;
  logic       w_op_we_nxt;
  logic       w_wr_drop_nxt;

  assign w_en        = ~i_phi1_NCEN_n;
  // An address captured in the same phi1 cycle takes effect before the data write.
  assign w_eff_addr  = r_addr_pend ? r_addr_buf : r_cur_addr;
  assign w_accept    = w_en & r_data_pend & ~r_busy;
  assign w_is_global = (w_eff_addr < 8'h20);
  assign w_target    = (r_wr_addr < 8'h40) ? {2'b00, r_wr_addr[2:0]} : r_wr_addr[4:0];
  assign w_slot_hit  = (r_slot == w_target);
  assign w_busy_zero = (r_busy_cnt == 8'd0);

  // Strobe capture runs on every EMUCLK edge; the slot counter and FSM only on enabled edges.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_addr_pend <= 1'b0;
      r_data_pend <= 1'b0;
      r_addr_buf  <= 8'h00;
      r_data_buf  <= 8'h00;
    end else begin
      if (w_en) begin
        r_addr_pend <= 1'b0;
        r_data_pend <= 1'b0;
      end
      // NOTE: the later non-blocking assignment wins, so a strobe landing on an
      // enabled edge re-arms its pend flag instead of being lost to the clear above.
      if (i_ADDR_WR) begin
        r_addr_pend <= 1'b1;
        r_addr_buf  <= i_DIN;
      end
      if (i_DATA_WR) begin
        r_data_pend <= 1'b1;
        r_data_buf  <= i_DIN;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_state    <= ST_IDLE;
      r_slot     <= 5'd0;
      r_cur_addr <= 8'h00;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_busy_cnt <= 8'd0;
      r_busy     <= 1'b0;
      r_reg_we   <= 1'b0;
      r_op_we    <= 1'b0;
      r_op_slot  <= 5'd0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      r_reg_we   <= w_reg_we_nxt;
      r_op_we    <= w_op_we_nxt;
      r_wr_drop  <= w_wr_drop_nxt;
      if (w_en) begin
        r_slot <= i_CYCLE_01 ? 5'd1 : r_slot + 5'd1;
        if (r_addr_pend) r_cur_addr <= r_addr_buf;
      end
      if (w_accept) begin
        r_wr_addr <= w_eff_addr;
        r_wr_data <= r_data_buf;
      end
      if (w_op_we_nxt) r_op_slot <= w_target;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_en) begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = w_is_global ? ST_HOLD : ST_WAIT;
        ST_WAIT: begin
          if (w_slot_hit)       w_state_nxt = ST_HOLD;
          else if (w_busy_zero) w_state_nxt = ST_IDLE;
        end
        ST_HOLD: if (w_busy_zero) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_busy_nxt     = r_busy;
    w_busy_cnt_nxt = r_busy_cnt;
    w_reg_we_nxt   = r_reg_we;
    w_op_we_nxt    = r_op_we;
    w_wr_drop_nxt  = r_wr_drop;
    if (w_en) begin
      w_reg_we_nxt  = 1'b0;
      w_op_we_nxt   = 1'b0;
      w_wr_drop_nxt = r_data_pend & r_busy;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_busy_nxt     = 1'b1;
            w_busy_cnt_nxt = BUSY_LOAD;
            w_reg_we_nxt   = w_is_global;
          end
        end
        ST_WAIT, ST_HOLD: begin
          w_op_we_nxt = (r_state == ST_WAIT) & w_slot_hit;
          if (w_busy_zero) w_busy_nxt = 1'b0;
          else             w_busy_cnt_nxt = r_busy_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_BUSY     = r_busy;
  assign o_REG_WE   = r_reg_we;
  assign o_OP_WE    = r_op_we;
  assign o_REG_ADDR = r_wr_addr;
  assign o_REG_DATA = r_wr_data;
  assign o_OP_SLOT  = r_op_slot;
  assign o_WR_DROP  = r_wr_drop;

endmodule

// File: tb/tb_ika2151_reg_sched.sv
// Bench for ika2151_reg_sched: directed vector table, hand-written reset/drop sequences,
// and randomized strobes checked every EMUCLK against a phi1-level reference model.
module tb_ika2151_reg_sched;

  localparam int BC = 64;

  logic       i_EMUCLK = 1'b0;
  logic       i_RST;
  logic       i_phi1_NCEN_n;
  logic       i_CYCLE_01;
  logic       i_ADDR_WR;
  logic       i_DATA_WR;
  logic [7:0] i_DIN;
  logic       o_BUSY;
  logic       o_REG_WE;
  logic       o_OP_WE;
  logic [7:0] o_REG_ADDR;
  logic [7:0] o_REG_DATA;
  logic [4:0] o_OP_SLOT;
  logic       o_WR_DROP;

  ika2151_reg_sched #(.BUSY_CYCLES(BC)) dut (
    .i_EMUCLK      (i_EMUCLK),
    .i_RST         (i_RST),
    .i_phi1_NCEN_n (i_phi1_NCEN_n),
    .i_CYCLE_01    (i_CYCLE_01),
    .i_ADDR_WR     (i_ADDR_WR),
    .i_DATA_WR     (i_DATA_WR),
    .i_DIN         (i_DIN),
    .o_BUSY        (o_BUSY),
    .o_REG_WE      (o_REG_WE),
    .o_OP_WE       (o_OP_WE),
    .o_REG_ADDR    (o_REG_ADDR),
    .o_REG_DATA    (o_REG_DATA),
    .o_OP_SLOT     (o_OP_SLOT),
    .o_WR_DROP     (o_WR_DROP)
  );

  always #5 i_EMUCLK = ~i_EMUCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phi1-level view built from the behavioural rules.
  bit         m_started = 1'b0;
  bit         m_in_rst;
  bit         m_a_pend, m_d_pend;
  logic [7:0] m_a_buf, m_d_buf, m_cur, m_waddr, m_wdata;
  logic [4:0] m_slot, m_tgt;
  int         m_busy_left;
  int         m_cd;
  bit         m_exp_reg_we, m_exp_op_we, m_exp_drop;

  always @(posedge i_EMUCLK) begin : ref_model
    logic [7:0] a_now;
    bit         pre_busy;
    m_started = 1'b1;
    m_in_rst  = i_RST;
    if (i_RST) begin
      m_a_pend = 0; m_d_pend = 0; m_a_buf = 0; m_d_buf = 0; m_cur = 0;
      m_waddr = 0; m_wdata = 0; m_slot = 0; m_tgt = 0;
      m_busy_left = 0; m_cd = 0;
      m_exp_reg_we = 0; m_exp_op_we = 0; m_exp_drop = 0;
    end else begin
      if (!i_phi1_NCEN_n) begin
        m_exp_reg_we = 0; m_exp_op_we = 0;
        a_now    = m_a_pend ? m_a_buf : m_cur;
        pre_busy = (m_busy_left > 0);
        if (m_a_pend) m_cur = m_a_buf;
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) m_exp_op_we = 1;
        end
        m_exp_drop = m_d_pend && pre_busy;
        if (m_busy_left > 0) m_busy_left--;
        if (m_d_pend && !pre_busy) begin
          m_busy_left = BC;
          m_waddr = a_now;
          m_wdata = m_d_buf;
          if (a_now < 8'h20) m_exp_reg_we = 1;
          else begin
            m_tgt = (a_now < 8'h40) ? 5'(a_now % 8) : 5'(a_now % 32);
            m_cd  = ((int'(m_tgt) - int'(m_slot) - 1) & 31) + 1;
          end
        end
        m_slot = i_CYCLE_01 ? 5'd1 : m_slot + 5'd1;
        m_a_pend = 0; m_d_pend = 0;
      end
      if (i_ADDR_WR) begin m_a_pend = 1; m_a_buf = i_DIN; end
      if (i_DATA_WR) begin m_d_pend = 1; m_d_buf = i_DIN; end
    end
  end

  always @(negedge i_EMUCLK) begin
    if (m_started) begin
      check("busy", o_BUSY, m_busy_left > 0);
      check("reg_we", o_REG_WE, m_exp_reg_we);
      check("op_we", o_OP_WE, m_exp_op_we);
      check("wr_drop", o_WR_DROP, m_exp_drop);
      if (m_exp_reg_we || m_exp_op_we) begin
        check("wr_addr", o_REG_ADDR, m_waddr);
        check("wr_data", o_REG_DATA, m_wdata);
      end
      if (m_exp_op_we) check("op_slot", o_OP_SLOT, m_tgt);
      if (m_in_rst) begin
        check("rst_addr", o_REG_ADDR, 0);
        check("rst_data", o_REG_DATA, 0);
        check("rst_slot", o_OP_SLOT, 0);
      end
    end
  end

  // Stimulus timing: phi1 enable every 4th EMUCLK (or random), CYCLE_01 once per 32 phi1.
  int ecnt = 0;
  int pc = 0;
  bit last_en = 1'b0;
  bit rand_en = 1'b0;

  task automatic step();
    last_en = !i_phi1_NCEN_n;
    @(posedge i_EMUCLK);
    #1;
    ecnt++;
    if (last_en) pc++;
    i_CYCLE_01 = (pc % 32 == 31);
    if (rand_en) i_phi1_NCEN_n = ($urandom_range(0, 2) != 0);
    else         i_phi1_NCEN_n = ((ecnt + 1) % 4 != 0);
  endtask

  task automatic next_phi();
    step();
    for (int i = 0; i < 64 && !last_en; i++) step();
  endtask

  task automatic strobe(input bit a, input bit d, input logic [7:0] din, input int width);
    i_ADDR_WR = a; i_DATA_WR = d; i_DIN = din;
    for (int i = 0; i < width; i++) step();
    i_ADDR_WR = 1'b0; i_DATA_WR = 1'b0;
  endtask

  task automatic align(input int s);
    int n;
    n = 0;
    next_phi();
    if (s >= 0) begin
      while (m_slot != 5'(s) && n < 64) begin
        next_phi();
        n++;
      end
      check("align_slot", m_slot, s);
    end
  endtask

  // mode 0: address in an earlier phi1, 1: address+data in the accepting phi1,
  // 2: as 0 plus a data write 0x77 and address 0x10 while BUSY, 3: data only.
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_addr;
    int         mode;
    int         acc_slot;
    bit         is_op;
    logic [4:0] exp_slot;
    int         we_edge;
    int         drops;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input int idx, input vec_t v);
    int busy_len, we_cnt, drop_cnt, we_edge;
    bit got_op;
    logic [7:0] got_addr, got_data;
    logic [4:0] got_slot;
    busy_len = 0; we_cnt = 0; drop_cnt = 0; we_edge = -1;
    got_op = 0; got_addr = 0; got_data = 0; got_slot = 0;
    if (v.mode == 0 || v.mode == 2) strobe(1'b1, 1'b0, v.addr, 1);
    align(v.acc_slot);
    if (v.mode == 1) strobe(1'b1, 1'b0, v.addr, 1);
    strobe(1'b0, 1'b1, v.data, 1);
    next_phi();
    for (int p = 0; p < 200; p++) begin
      if (o_BUSY) busy_len++;
      if (o_WR_DROP) drop_cnt++;
      if (o_REG_WE || o_OP_WE) begin
        we_cnt++; we_edge = p; got_op = o_OP_WE;
        got_addr = o_REG_ADDR; got_data = o_REG_DATA; got_slot = o_OP_SLOT;
      end
      if (!o_BUSY) break;
      if (v.mode == 2 && p == 3) begin
        strobe(1'b0, 1'b1, 8'h77, 1);
        strobe(1'b1, 1'b0, 8'h10, 1);
      end
      next_phi();
    end
    check($sformatf("v%0d_we_edge", idx), we_edge, v.we_edge);
    check($sformatf("v%0d_we_count", idx), we_cnt, 1);
    check($sformatf("v%0d_is_op", idx), got_op, v.is_op);
    check($sformatf("v%0d_addr", idx), got_addr, v.exp_addr);
    check($sformatf("v%0d_data", idx), got_data, v.data);
    if (v.is_op) check($sformatf("v%0d_slot", idx), got_slot, v.exp_slot);
    check($sformatf("v%0d_busy_len", idx), busy_len, BC);
    check($sformatf("v%0d_drops", idx), drop_cnt, v.drops);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int opwe_cnt, busy_cnt;
    int r;
    vecs[0]  = '{8'h08, 8'h5A, 8'h08, 0, -1, 1'b0, 5'd0,  0, 0};
    vecs[1]  = '{8'h6D, 8'h1F, 8'h6D, 0, 20, 1'b1, 5'd13, 25, 0};
    vecs[2]  = '{8'h2B, 8'h33, 8'h2B, 0,  5, 1'b1, 5'd3, 30, 0};
    vecs[3]  = '{8'h1F, 8'hC3, 8'h1F, 0, -1, 1'b0, 5'd0,  0, 0};
    vecs[4]  = '{8'h20, 8'h44, 8'h20, 0,  0, 1'b1, 5'd0, 32, 0};
    vecs[5]  = '{8'h3F, 8'h12, 8'h3F, 0,  6, 1'b1, 5'd7,  1, 0};
    vecs[6]  = '{8'hFF, 8'hEE, 8'hFF, 0, 30, 1'b1, 5'd31, 1, 0};
    vecs[7]  = '{8'h40, 8'h01, 8'h40, 0, 31, 1'b1, 5'd0,  1, 0};
    vecs[8]  = '{8'h6D, 8'h1F, 8'h6D, 2, 20, 1'b1, 5'd13, 25, 1};
    vecs[9]  = '{8'h00, 8'h21, 8'h10, 3, -1, 1'b0, 5'd0,  0, 0};
    vecs[10] = '{8'h0F, 8'h99, 8'h0F, 1, -1, 1'b0, 5'd0,  0, 0};

    i_RST = 1'b1; i_phi1_NCEN_n = 1'b1; i_CYCLE_01 = 1'b0;
    i_ADDR_WR = 1'b0; i_DATA_WR = 1'b0; i_DIN = 8'h00;
    for (int i = 0; i < 8; i++) step();
    check("reset_busy", o_BUSY, 0);
    check("reset_reg_we", o_REG_WE, 0);
    check("reset_op_we", o_OP_WE, 0);
    check("reset_addr", o_REG_ADDR, 0);
    check("reset_data", o_REG_DATA, 0);
    check("reset_slot", o_OP_SLOT, 0);
    check("reset_drop", o_WR_DROP, 0);
    i_RST = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("post_reset_busy", o_BUSY, 0);
    check("post_reset_we", {o_REG_WE, o_OP_WE, o_WR_DROP}, 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while a slot write is waiting: the write must be abandoned.
    strobe(1'b1, 1'b0, 8'h6D, 1);
    align(20);
    strobe(1'b0, 1'b1, 8'h1F, 1);
    next_phi();
    check("wait_busy", o_BUSY, 1);
    for (int i = 0; i < 5; i++) next_phi();
    i_RST = 1'b1;
    step(); step();
    i_RST = 1'b0;
    check("rst_wait_busy", o_BUSY, 0);
    opwe_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      next_phi();
      if (o_OP_WE) opwe_cnt++;
      if (o_BUSY) busy_cnt++;
    end
    check("rst_wait_no_opwe", opwe_cnt, 0);
    check("rst_wait_no_busy", busy_cnt, 0);

    // Randomized strobes and enable spacing against the reference model.
    rand_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 1)      strobe(1'b1, 1'b0, 8'($urandom), $urandom_range(1, 2));
      else if (r <= 4) strobe(1'b0, 1'b1, 8'($urandom), $urandom_range(1, 2));
      else if (r == 5) begin
        strobe(1'b1, 1'b0, 8'($urandom), 1);
        strobe(1'b0, 1'b1, 8'($urandom), 1);
      end else step();
    end
    rand_en = 1'b0;
    for (int i = 0; i < 400; i++) step();
    check("drain_busy", o_BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
